// File: rtl/ram32_pkg.sv
// Shared definitions for the RAM32 port arbiter: data/byte-enable widths,
// requester ids, controller states and the byte-merge helper used by the
// optional same-cycle write bypass (RAM32_BYPASS_EN).
package ram32_pkg;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte-wise merge: byte i comes from new_data when sel[i] is set, else old_data.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [BE_W-1:0]   sel
  );
    logic [DATA_W-1:0] res;
    res = old_data;
    for (int i = 0; i < BE_W; i++) begin
      if (sel[i]) begin
        res[i*8 +: 8] = new_data[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_data[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram32_port_arbiter_rr_arb2.sv
// Two-way round-robin grant for the shared read port. Grants are
// combinational from the request lines; the pointer only moves on a
// contended grant, so an uncontested requester never loses its turn.
module ram32_rr_arb2
  import ram32_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t rr;
  req_id_t rr_next;

  // Grant selection and next pointer value.
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    rr_next = rr;
    if (en) begin
      case ({req_a, req_b})
        2'b10: gnt_a = 1'b1;
        2'b01: gnt_b = 1'b1;
        2'b11: begin
          if (rr == REQ_A) begin
            gnt_a   = 1'b1;
            rr_next = REQ_B;
          end else begin
            gnt_b   = 1'b1;
            rr_next = REQ_A;
          end
        end
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end else begin
      gnt_a   = 1'b0;
      gnt_b   = 1'b0;
      rr_next = rr;
    end
  end

  // Round-robin pointer register; starts favouring requester A.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rr <= REQ_A;
    end else begin
      rr <= rr_next;
    end
  end

endmodule

// File: rtl/ram32_port_arbiter.sv
// Controller in front of a RAM32_1RW1R macro. Port 0 zero-fills the array
// after reset and then serves the single writer; port 1 is the read path,
// shared round-robin between requesters A and B. Responses come one cycle
// after the grant. Optional macro RAM32_BYPASS_EN forwards a same-cycle
// write to the same address into the read response.
module ram32_port_arbiter
  import ram32_pkg::*;
#(
  parameter int BITS = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              init_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BITS-1:0]   wr_addr,
  input  logic [BE_W-1:0]   wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rda_valid,
  output logic              rda_ready,
  input  logic [BITS-1:0]   rda_addr,
  output logic              rda_rvalid,
  output logic [DATA_W-1:0] rda_rdata,
  input  logic              rdb_valid,
  output logic              rdb_ready,
  input  logic [BITS-1:0]   rdb_addr,
  output logic              rdb_rvalid,
  output logic [DATA_W-1:0] rdb_rdata,
  output logic              ram_en0,
  output logic [BITS-1:0]   ram_a0,
  output logic [BE_W-1:0]   ram_we0,
  output logic [DATA_W-1:0] ram_di0,
  output logic              ram_en1,
  output logic [BITS-1:0]   ram_a1,
  input  logic [DATA_W-1:0] ram_do1
);

  state_t            state;
  state_t            state_next;
  logic [BITS-1:0]   init_cnt;
  logic              init_last;
  logic              run;
  logic              gnt_a;
  logic              gnt_b;
  req_id_t           rsp_id;
  logic [DATA_W-1:0] rsp_data;

  assign init_last = (init_cnt == {BITS{1'b1}});
  assign run       = (state == ST_RUN);

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave INIT after the cycle that writes the last entry.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: begin
        if (init_last) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_INIT;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Zero-fill address counter, advancing once per INIT cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      init_cnt <= {BITS{1'b0}};
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end else begin
      init_cnt <= init_cnt;
    end
  end

  // init_done rises in the first RUN cycle and stays high until reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      init_done <= 1'b0;
    end else begin
      init_done <= (state_next == ST_RUN);
    end
  end

  // Port 0 drive: zero-fill during INIT, pass-through writer during RUN.
  always_comb begin
    ram_en0  = 1'b0;
    ram_a0   = {BITS{1'b0}};
    ram_we0  = {BE_W{1'b0}};
    ram_di0  = {DATA_W{1'b0}};
    wr_ready = 1'b0;
    case (state)
      ST_INIT: begin
        ram_en0 = 1'b1;
        ram_a0  = init_cnt;
        ram_we0 = {BE_W{1'b1}};
        ram_di0 = {DATA_W{1'b0}};
      end
      ST_RUN: begin
        wr_ready = 1'b1;
        ram_en0  = wr_valid;
        ram_a0   = wr_addr;
        ram_we0  = wr_sel;
        ram_di0  = wr_data;
      end
      default: begin
        ram_en0  = 1'b0;
        wr_ready = 1'b0;
      end
    endcase
  end

  ram32_rr_arb2 u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (run),
    .req_a (rda_valid),
    .req_b (rdb_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Port 1 drive from the current grant.
  always_comb begin
    rda_ready = gnt_a;
    rdb_ready = gnt_b;
    ram_en1   = gnt_a | gnt_b;
    if (gnt_b) begin
      ram_a1 = rdb_addr;
    end else begin
      ram_a1 = rda_addr;
    end
  end

  // Response strobes and the id of the side that owns Do1 next cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rda_rvalid <= 1'b0;
      rdb_rvalid <= 1'b0;
      rsp_id     <= REQ_A;
    end else begin
      rda_rvalid <= gnt_a;
      rdb_rvalid <= gnt_b;
      if (gnt_a || gnt_b) begin
        rsp_id <= gnt_b ? REQ_B : REQ_A;
      end else begin
        rsp_id <= rsp_id;
      end
    end
  end

`ifdef RAM32_BYPASS_EN
  logic              byp_hit;
  logic [BE_W-1:0]   byp_sel;
  logic [DATA_W-1:0] byp_data;
  logic              hit_now;

  assign hit_now = run && wr_valid && (gnt_a || gnt_b) && (wr_addr == ram_a1);

  // Capture a same-cycle write to the granted address for forwarding.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      byp_hit  <= 1'b0;
      byp_sel  <= {BE_W{1'b0}};
      byp_data <= {DATA_W{1'b0}};
    end else if (gnt_a || gnt_b) begin
      byp_hit  <= hit_now;
      byp_sel  <= wr_sel;
      byp_data <= wr_data;
    end else begin
      byp_hit  <= 1'b0;
      byp_sel  <= byp_sel;
      byp_data <= byp_data;
    end
  end

  // Response data: macro output with forwarded write bytes merged in.
  always_comb begin
    if (byp_hit) begin
      rsp_data = byte_merge(ram_do1, byp_data, byp_sel);
    end else begin
      rsp_data = ram_do1;
    end
  end
`else
  // Response data: macro output as-is (pre-write contents on collision).
  always_comb begin
    rsp_data = ram_do1;
  end
`endif

  // Steer response data to the owning side; the other side reads zero.
  always_comb begin
    rda_rdata = {DATA_W{1'b0}};
    rdb_rdata = {DATA_W{1'b0}};
    if (rda_rvalid && (rsp_id == REQ_A)) begin
      rda_rdata = rsp_data;
    end else begin
      rda_rdata = {DATA_W{1'b0}};
    end
    if (rdb_rvalid && (rsp_id == REQ_B)) begin
      rdb_rdata = rsp_data;
    end else begin
      rdb_rdata = {DATA_W{1'b0}};
    end
  end

endmodule
